currctrl_seq: RTL and testbench

CURRCTRL_SEQ -- requirements
Module: currctrl_seq

---
 rtl/currctrl_seq.sv | 178 +++++++++++++++++
 tb/tb_currctrl_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/currctrl_seq.sv
// Current-setpoint sequencer: walks a setpoint table in the lower half of a RAM
// port, presents each entry to the control loop, and logs the measured current
// into the upper half. Steps are paced by a prescaler tick of rate_div+1 clocks.
module currctrl_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [ADDR_W-2:0]   last_idx,
  input  logic [PRESC_W-1:0]  rate_div,
  input  logic [DATA_W-1:0]   meas_current,
  output logic [ADDR_W-1:0]   address2,
  output logic                chipselect2,
  output logic                write2,
  output logic [DATA_W/8-1:0] byteenable2,
  output logic [DATA_W-1:0]   writedata2,
  output logic                clken2,
  input  logic [DATA_W-1:0]   readdata2,
  output logic [DATA_W-1:0]   setpoint,
  output logic                setpoint_valid,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [ADDR_W-2:0]   step_idx
);

  typedef enum logic [2:0] {StIdle, StRead, StLatch, StCapture, StWait} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-2:0]   idx_q, idx_d;
  logic [ADDR_W-2:0]   last_q;
  logic [PRESC_W-1:0]  rate_q;
  logic                loop_q;
  logic [PRESC_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   setpoint_q, setpoint_d;
  logic                sp_valid_q, sp_valid_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic start_ok;
  logic tick;
  logic last_hit;

  assign busy     = (state_q != StIdle);
  assign start_ok = start && !stop && (state_q == StIdle);
  assign tick     = busy && (cnt_q == rate_q);
  assign last_hit = (idx_q == last_q);

  // Next-state, index and status flags
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    setpoint_d = setpoint_q;
    sp_valid_d = 1'b0;
    overrun_d  = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRead;
          idx_d   = '0;
        end
      end
      StRead:    state_d = StLatch;
      StLatch: begin
        state_d    = StCapture;
        setpoint_d = readdata2;
        sp_valid_d = 1'b1;
      end
      StCapture: state_d = StWait;
      StWait: begin
        if (tick) begin
          if (!last_hit) begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end else if (loop_q) begin
            idx_d   = '0;
            state_d = StRead;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A tick outside WAIT means the step period is too short for one table access
    if (start_ok) begin
      overrun_d = 1'b0;
    end else if (tick && (state_q != StWait)) begin
      overrun_d = 1'b1;
    end

    // stop overrides everything, including a start in the same clock
    if (stop) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      setpoint_d = '0;
      sp_valid_d = 1'b0;
    end
  end

  // Step prescaler: counts 0..rate_div while busy, restarted on every accepted start
  always_comb begin
    cnt_d = '0;
    if (busy && !stop && (cnt_q != rate_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      last_q     <= '0;
      rate_q     <= '0;
      loop_q     <= 1'b0;
      cnt_q      <= '0;
      setpoint_q <= '0;
      sp_valid_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      setpoint_q <= setpoint_d;
      sp_valid_q <= sp_valid_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      if (start_ok) begin
        last_q <= last_idx;
        rate_q <= rate_div;
        loop_q <= loop;
      end
    end
  end

  // RAM port-2 strobes decode the state alone so a stop cannot extend a write
  always_comb begin
    address2    = '0;
    chipselect2 = 1'b0;
    write2      = 1'b0;
    writedata2  = '0;
    clken2      = 1'b0;
    byteenable2 = '1;
    unique case (state_q)
      StRead: begin
        address2    = {1'b0, idx_q};
        chipselect2 = 1'b1;
        clken2      = 1'b1;
      end
      StCapture: begin
        address2    = {1'b1, idx_q};
        writedata2  = meas_current;
        chipselect2 = 1'b1;
        write2      = 1'b1;
        clken2      = 1'b1;
      end
      default: ;
    endcase
  end

  assign setpoint       = setpoint_q;
  assign setpoint_valid = sp_valid_q;
  assign done           = done_q;
  assign overrun        = overrun_q;
  assign step_idx       = idx_q;

endmodule

// File: tb/tb_currctrl_seq.sv
// Scoreboard bench for currctrl_seq: stimulus pushes expected setpoints and
// capture writes; a monitor pops and compares whenever the DUT presents them.
module tb_currctrl_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [6:0]  last_idx = '0;
  logic [15:0] rate_div = '0;
  logic [31:0] meas_current = '0;
  logic [7:0]  address2;
  logic        chipselect2;
  logic        write2;
  logic [3:0]  byteenable2;
  logic [31:0] writedata2;
  logic        clken2;
  logic [31:0] readdata2 = '0;
  logic [31:0] setpoint;
  logic        setpoint_valid;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [6:0]  step_idx;

  currctrl_seq dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .loop           (loop),
    .last_idx       (last_idx),
    .rate_div       (rate_div),
    .meas_current   (meas_current),
    .address2       (address2),
    .chipselect2    (chipselect2),
    .write2         (write2),
    .byteenable2    (byteenable2),
    .writedata2     (writedata2),
    .clken2         (clken2),
    .readdata2      (readdata2),
    .setpoint       (setpoint),
    .setpoint_valid (setpoint_valid),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun),
    .step_idx       (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sp;
    logic [6:0]  idx;
    int          gap;
  } sp_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  sp_exp_t sp_q[$];
  wr_exp_t wr_q[$];

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_sp_cyc = 0;
  int sp_seen = 0;
  int wr_seen = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_step(input int idx, input int gap, input logic [31:0] meas);
    sp_exp_t s;
    wr_exp_t w;
    s.sp  = 32'(idx * 16);
    s.idx = 7'(idx);
    s.gap = gap;
    sp_q.push_back(s);
    w.addr = 8'(128 + idx);
    w.data = meas;
    wr_q.push_back(w);
  endfunction

  // Synchronous RAM model: read data valid one clock after the address cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chipselect2 && clken2) begin
      if (write2) mem[address2] <= writedata2;
      else        readdata2     <= mem[address2];
    end
  end

  // Monitor: pops expectations whenever the DUT presents a setpoint or a capture write
  always @(negedge clk) begin
    if (reset_n) begin
      if (setpoint_valid) begin
        if (sp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_setpoint: got 0x%0h expected no update", setpoint);
        end else begin
          sp_exp_t e;
          e = sp_q.pop_front();
          chk("setpoint", 64'(setpoint), 64'(e.sp));
          chk("step_idx", 64'(step_idx), 64'(e.idx));
          if (e.gap != 0) chk("step_gap", 64'(cyc - last_sp_cyc), 64'(e.gap));
        end
        last_sp_cyc = cyc;
        sp_seen++;
      end
      if (write2) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h expected no write", address2);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          chk("capture_addr", 64'(address2), 64'(w.addr));
          chk("capture_data", 64'(writedata2), 64'(w.data));
          chk("capture_be", 64'(byteenable2), 64'hf);
        end
        wr_seen++;
      end
      if (done) done_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_count;
    int k = 0;
    while (done_count == d0 && k < bound) begin
      step(1);
      k++;
    end
    if (done_count == d0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  task automatic wait_sp(input int target, input int bound);
    int k = 0;
    while (sp_seen < target && k < bound) begin
      step(1);
      k++;
    end
    if (sp_seen < target) begin
      checks++;
      errors++;
      $display("FAIL wait_setpoint: got %0d expected %0d", sp_seen, target);
    end
  endtask

  // Leaves the caller at the negedge where setpoint_valid is high
  task automatic wait_valid_negedge(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!setpoint_valid && k < bound);
    if (!setpoint_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got timeout expected setpoint_valid");
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_setpoint"}, 64'(setpoint), 64'h0);
    chk({tag, "_flags"}, 64'({setpoint_valid, busy, done, overrun}), 64'h0);
    chk({tag, "_step_idx"}, 64'(step_idx), 64'h0);
    chk({tag, "_ram_ctl"}, 64'({address2, chipselect2, write2, clken2}), 64'h0);
    chk({tag, "_wdata"}, 64'(writedata2), 64'h0);
    chk({tag, "_be"}, 64'(byteenable2), 64'hf);
  endtask

  initial begin
    int d0;
    int s0;
    for (int i = 0; i < 256; i++) mem[i] = (i < 128) ? 32'(i * 16) : 32'h0;

    // Reset state
    step(2);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    step(2);

    // Single pass, rate_div=9: 4 steps, 10 clocks apart, one done pulse
    meas_current = 32'h0000_beef;
    rate_div = 16'd9;
    last_idx = 7'd3;
    loop = 1'b0;
    for (int i = 0; i < 4; i++) push_step(i, (i == 0) ? 0 : 10, 32'h0000_beef);
    d0 = done_count;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'h1);
    wait_done(200);
    step(3);
    chk("single_done_count", 64'(done_count - d0), 64'h1);
    chk("single_busy_end", 64'(busy), 64'h0);
    chk("single_setpoint_hold", 64'(setpoint), 64'h30);
    chk("single_ram_capture", 64'(mem[8'h83]), 64'h0000_beef);
    chk("single_sp_queue", 64'(sp_q.size()), 64'h0);
    chk("single_wr_queue", 64'(wr_q.size()), 64'h0);

    // Looping: 10 steps wrap 0..3, then stop; done never pulses
    loop = 1'b1;
    meas_current = 32'h0a0a_5555;
    for (int i = 0; i < 10; i++) push_step(i % 4, (i == 0) ? 0 : 10, 32'h0a0a_5555);
    d0 = done_count;
    s0 = sp_seen;
    pulse_start();
    wait_sp(s0 + 10, 300);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("loop_stop_busy", 64'(busy), 64'h0);
    chk("loop_stop_setpoint", 64'(setpoint), 64'h0);
    step(15);
    chk("loop_no_done", 64'(done_count - d0), 64'h0);
    chk("loop_sp_queue", 64'(sp_q.size()), 64'h0);
    chk("loop_wr_queue", 64'(wr_q.size()), 64'h0);

    // Stop while in CAPTURE: write drops on the next clock, no done
    loop = 1'b0;
    meas_current = 32'h0000_0c0c;
    push_step(0, 0, 32'h0000_0c0c);
    d0 = done_count;
    pulse_start();
    wait_valid_negedge(50);
    chk("capture_write_high", 64'(write2), 64'h1);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk("stop_write_low", 64'({write2, chipselect2}), 64'h0);
    chk("stop_busy", 64'(busy), 64'h0);
    chk("stop_setpoint", 64'(setpoint), 64'h0);
    step(30);
    chk("stop_no_done", 64'(done_count - d0), 64'h0);
    chk("stop_wr_queue", 64'(wr_q.size()), 64'h0);

    // start and stop together from IDLE: nothing happens
    s0 = sp_seen;
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", 64'(busy), 64'h0);
    step(5);
    chk("startstop_busy_later", 64'(busy), 64'h0);
    chk("startstop_no_step", 64'(sp_seen - s0), 64'h0);

    // rate_div=1: every step overruns, flag sticks until the next start
    chk("overrun_clear_before", 64'(overrun), 64'h0);
    rate_div = 16'd1;
    meas_current = 32'h1234_5678;
    for (int i = 0; i < 4; i++) push_step(i, (i == 0) ? 0 : 4, 32'h1234_5678);
    s0 = sp_seen;
    pulse_start();
    wait_sp(s0 + 2, 100);
    chk("overrun_set", 64'(overrun), 64'h1);
    wait_done(100);
    step(5);
    chk("overrun_sticky", 64'(overrun), 64'h1);
    rate_div = 16'd9;
    meas_current = 32'h0000_beef;
    for (int i = 0; i < 4; i++) push_step(i, (i == 0) ? 0 : 10, 32'h0000_beef);
    pulse_start();
    chk("overrun_cleared_by_start", 64'(overrun), 64'h0);
    wait_done(200);
    chk("overrun_stays_clear", 64'(overrun), 64'h0);

    // Asynchronous reset while in WAIT at step 1
    loop = 1'b1;
    meas_current = 32'h0000_7777;
    push_step(0, 0, 32'h0000_7777);
    push_step(1, 10, 32'h0000_7777);
    pulse_start();
    wait_valid_negedge(50);
    wait_valid_negedge(50);
    @(negedge clk);
    chk("pre_reset_idx", 64'(step_idx), 64'h1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    step(2);
    reset_n = 1'b1;
    step(5);
    chk("post_reset_busy", 64'(busy), 64'h0);
    chk("final_sp_queue", 64'(sp_q.size()), 64'h0);
    chk("final_wr_queue", 64'(wr_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
